snn_tdm_scheduler: RTL

Time-multiplexed controller that shares one leaky-integrate-and-fire (LIF) update datapath among N virtual neurons. Each `step` pulse samples the 8-bit input, updates every neuron's membrane and refractory state one per cycle, then presents the packed spike vector through a valid/ready handshake. The block sits between the `ui_in` stimulus and the `uo_out` spike outputs. It replaces per-neuron hardware with one shared datapath.

---
 rtl/snn_pkg.sv | 18 +
 rtl/snn_lif_update.sv | 54 +++++
 rtl/snn_tdm_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and widths for the time-multiplexed LIF neuron scheduler.
//   state_t : scheduler FSM states
//   V_W     : membrane potential and weight width
//   R_W     : refractory counter width
//   MAX_N   : storage depth of the per-neuron state arrays
package snn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int V_W   = 8;
  localparam int R_W   = 4;
  localparam int MAX_N = 8;

endpackage

// File: rtl/snn_lif_update.sv
// Combinational leaky-integrate-and-fire update for one neuron.
// Ports:
//   v, refr, w  : current membrane, refractory count and weight of the neuron
//   in_q        : input current captured for this time step
//   v_next      : next membrane value
//   refr_next   : next refractory count
//   fire        : neuron spikes in this step
module snn_lif_update
  import snn_pkg::*;
#(
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 2
) (
  input  logic [V_W-1:0] v,
  input  logic [R_W-1:0] refr,
  input  logic [V_W-1:0] w,
  input  logic [V_W-1:0] in_q,
  output logic [V_W-1:0] v_next,
  output logic [R_W-1:0] refr_next,
  output logic           fire
);

  // Clamp the 9-bit integration sum to the 8-bit membrane range.
  function automatic logic [V_W-1:0] sat_v(input logic [V_W:0] s);
    return s[V_W] ? {V_W{1'b1}} : s[V_W-1:0];
  endfunction

  logic [2*V_W-1:0] prod;
  logic [V_W-1:0]   cur;
  logic [V_W:0]     sum;
  logic [V_W-1:0]   s_sat;

  always_comb begin
    prod  = {{V_W{1'b0}}, in_q} * {{V_W{1'b0}}, w};
    cur   = V_W'(prod >> V_W);
    // v - (v >> k) never underflows, and adding an 8-bit current fits in 9 bits.
    sum   = {1'b0, v} - {1'b0, (v >> LEAK_SHIFT)} + {1'b0, cur};
    s_sat = sat_v(sum);

    v_next    = s_sat;
    refr_next = '0;
    fire      = 1'b0;
    if (refr != '0) begin
      v_next    = '0;
      refr_next = refr - R_W'(1);
    end else if (s_sat >= V_W'(THRESHOLD)) begin
      v_next    = '0;
      refr_next = R_W'(REFRACT);
      fire      = 1'b1;
    end
  end

endmodule

// File: rtl/snn_tdm_scheduler.sv
// Shares one LIF datapath among N_NEURONS virtual neurons. A step request
// captures the input current, sweeps the neurons one per cycle, then offers
// the packed spike vector on a valid/ready handshake.
// Ports:
//   clk, reset            : clock and asynchronous active-high reset
//   step, neuron_input    : time-step request and its input current
//   cfg_we/addr/data      : per-neuron weight write port
//   spike_vec/valid/ready : spike result handshake
//   busy                  : sweep in progress
//   step_drop             : pulse one cycle after a rejected step
module snn_tdm_scheduler
  import snn_pkg::*;
#(
  parameter int             N_NEURONS  = 4,
  parameter int             THRESHOLD  = 200,
  parameter int             LEAK_SHIFT = 3,
  parameter int             REFRACT    = 2,
  parameter logic [V_W-1:0] W_INIT     = 8'h80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic [V_W-1:0]       neuron_input,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [V_W-1:0]       cfg_data,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 spike_valid,
  input  logic                 spike_ready,
  output logic                 busy,
  output logic                 step_drop
);

  state_t               state;
  logic [2:0]           idx;
  logic [V_W-1:0]       in_q;
  logic [N_NEURONS-1:0] spike_acc;

  // Arrays are sized for the largest configuration so the 3-bit index and
  // address always fit; entries at or above N_NEURONS are never written.
  logic [V_W-1:0] v_mem    [MAX_N];
  logic [R_W-1:0] refr_mem [MAX_N];
  logic [V_W-1:0] w_mem    [MAX_N];

  logic [V_W-1:0]       lif_v_next;
  logic [R_W-1:0]       lif_refr_next;
  logic                 lif_fire;
  logic [N_NEURONS-1:0] fire_mask;

  // Shared datapath: reads the neuron selected by idx, before any weight
  // write landing on the same edge.
  snn_lif_update #(
    .THRESHOLD  (THRESHOLD),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT)
  ) u_lif (
    .v         (v_mem[idx]),
    .refr      (refr_mem[idx]),
    .w         (w_mem[idx]),
    .in_q      (in_q),
    .v_next    (lif_v_next),
    .refr_next (lif_refr_next),
    .fire      (lif_fire)
  );

  assign fire_mask = N_NEURONS'(lif_fire) << idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      in_q        <= '0;
      spike_acc   <= '0;
      spike_vec   <= '0;
      spike_valid <= 1'b0;
      busy        <= 1'b0;
      step_drop   <= 1'b0;
      for (int i = 0; i < MAX_N; i++) begin
        v_mem[i]    <= '0;
        refr_mem[i] <= '0;
        w_mem[i]    <= W_INIT;
      end
    end else begin
      step_drop <= 1'b0;

      if (cfg_we && ({1'b0, cfg_addr} < 4'(N_NEURONS)))
        w_mem[cfg_addr] <= cfg_data;

      case (state)
        IDLE: begin
          if (step) begin
            in_q      <= neuron_input;
            idx       <= '0;
            spike_acc <= '0;
            busy      <= 1'b1;
            state     <= UPDATE;
          end
        end

        // Sweep boundary: one neuron committed per edge.
        UPDATE: begin
          v_mem[idx]    <= lif_v_next;
          refr_mem[idx] <= lif_refr_next;
          if (step)
            step_drop <= 1'b1;
          if (idx == 3'(N_NEURONS - 1)) begin
            spike_vec   <= spike_acc | fire_mask;
            spike_valid <= 1'b1;
            busy        <= 1'b0;
            state       <= HOLD;
          end else begin
            spike_acc <= spike_acc | fire_mask;
            idx       <= idx + 3'd1;
          end
        end

        // Result boundary: spike_vec held until the consumer takes it.
        HOLD: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            if (step) begin
              in_q      <= neuron_input;
              idx       <= '0;
              spike_acc <= '0;
              busy      <= 1'b1;
              state     <= UPDATE;
            end else begin
              state <= IDLE;
            end
          end else if (step) begin
            step_drop <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
